bch_dec_sched: RTL and testbench

Round-robin scheduler that shares one BCH decoder instance among N_REQ independent codeword sources (e.g. the per-link receive paths feeding the ESP32 transfer). It accepts one codeword at a time from a requester, sequences the decoder's start/done handshake, and returns the corrected data, error count and failure status to the owning requester only. It sits between the receive framers and the single `bch_decode`-style datapath.

---
 rtl/bch_sched_pkg.sv | 17 +
 rtl/bch_dec_sched_if.sv | 34 +++
 rtl/bch_rr_arbiter.sv | 31 +++
 rtl/bch_dec_sched.sv | 135 +++++++++++++
 tb/tb_bch_dec_sched.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bch_sched_pkg.sv
// Shared types and constants for the BCH decoder scheduler.
package bch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/bch_dec_sched_if.sv
// Requester and decoder handshake bundle for bch_dec_sched.
interface bch_dec_sched_if #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_BITS = 5,
  parameter int unsigned CODE_BITS = 15,
  parameter int unsigned NERR_W    = 3
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*CODE_BITS-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ-1:0]           resp_valid;
  logic [DATA_BITS-1:0]       resp_data;
  logic [NERR_W-1:0]          resp_nerr;
  logic [1:0]                 resp_status;
  logic                       dec_start;
  logic [CODE_BITS-1:0]       dec_data_in;
  logic                       dec_ready;
  logic                       dec_done;
  logic [DATA_BITS-1:0]       dec_data_out;
  logic [NERR_W-1:0]          dec_nerr;
  logic                       dec_fail;

  // Scheduler side
  modport slave (
    input  req_valid, req_data, dec_ready, dec_done, dec_data_out, dec_nerr, dec_fail,
    output req_ready, resp_valid, resp_data, resp_nerr, resp_status, dec_start, dec_data_in
  );

  // Requesters plus decoder side
  modport master (
    output req_valid, req_data, dec_ready, dec_done, dec_data_out, dec_nerr, dec_fail,
    input  req_ready, resp_valid, resp_data, resp_nerr, resp_status, dec_start, dec_data_in
  );
endinterface

// File: rtl/bch_rr_arbiter.sv
// Combinational rotating-priority pick: first valid requester at or after rr_ptr.
module bch_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int unsigned k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(rr_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!grant_any && req_valid[k]) begin
        grant_any = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bch_dec_sched.sv
// Round-robin scheduler sharing one BCH decoder among N_REQ requesters.
// Optional watchdog on the decoder wait: define BCH_SCHED_TIMEOUT_EN.
module bch_dec_sched
  import bch_sched_pkg::*;
#(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned DATA_BITS = 5,
  parameter  int unsigned CODE_BITS = 15,
  parameter  int unsigned T         = 3,
  parameter  int unsigned TIMEOUT   = 255,
  localparam int unsigned NERR_W    = $clog2(T + 2),
  localparam int unsigned IDX_W     = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  bch_dec_sched_if.slave    bus,
  output logic              busy
);

  state_t               state, state_nx;
  logic [IDX_W-1:0]     rr_ptr, owner, gnt_idx;
  logic [N_REQ-1:0]     gnt;
  logic                 gnt_any;
  logic [CODE_BITS-1:0] sel_word, data_in_q;
  logic [DATA_BITS-1:0] resp_data_q;
  logic [NERR_W-1:0]    resp_nerr_q;
  logic [1:0]           resp_status_q;
  logic                 tmo_hit;

  bch_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

`ifdef BCH_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            tmo_cnt <= '0;
    else if (state != WAIT)  tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Counter reads 0 on the first WAIT cycle, so TIMEOUT-1 marks the last allowed one
  assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) sel_word = bus.req_data[i*CODE_BITS +: CODE_BITS];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.dec_start  = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by reset so an asserted reset forces every output low
        if (gnt_any && reset_n) begin
          bus.req_ready = gnt;
          state_nx      = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dec_ready) begin
          bus.dec_start = 1'b1;
          state_nx      = WAIT;
        end
      end
      WAIT: begin
        if (bus.dec_done || tmo_hit) state_nx = RESP;
      end
      RESP: begin
        bus.resp_valid = N_REQ'(1) << owner;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      owner         <= '0;
      data_in_q     <= '0;
      resp_data_q   <= '0;
      resp_nerr_q   <= '0;
      resp_status_q <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner     <= gnt_idx;
            data_in_q <= sel_word;
          end
        end
        WAIT: begin
          // A completion on the expiry cycle takes precedence over the timeout
          if (bus.dec_done) begin
            resp_data_q   <= bus.dec_data_out;
            resp_nerr_q   <= bus.dec_nerr;
            resp_status_q <= bus.dec_fail ? ST_FAIL : ST_OK;
          end else if (tmo_hit) begin
            resp_data_q   <= '0;
            resp_nerr_q   <= '0;
            resp_status_q <= ST_TIMEOUT;
          end
        end
        RESP: rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.dec_data_in = data_in_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_nerr   = resp_nerr_q;
  assign bus.resp_status = resp_status_q;

endmodule

// File: tb/tb_bch_dec_sched.sv
// Directed self-checking bench for bch_dec_sched; decoder handshake driven by hand.
module tb_bch_dec_sched;

`ifdef BCH_SCHED_TIMEOUT_EN
  localparam int unsigned TMO = 20;
`else
  localparam int unsigned TMO = 255;
`endif

  logic clk;
  logic reset_n;
  logic busy;
  int   checks;
  int   errors;
  logic [14:0] word [4];

  bch_dec_sched_if #(.N_REQ(4), .DATA_BITS(5), .CODE_BITS(15), .NERR_W(3)) bus ();

  bch_dec_sched #(
    .N_REQ(4), .DATA_BITS(5), .CODE_BITS(15), .T(3), .TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle with req_valid already driven; returns in the following IDLE cycle
  task automatic serve(input int unsigned idx, input int unsigned rdy_dly, input int unsigned lat,
                       input logic [4:0] dout, input logic [2:0] nerr, input logic fail);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 0);
    bus.dec_ready = (rdy_dly == 0);
    step();
    for (int i = 0; i < int'(rdy_dly); i++) begin
      #1;
      chk("start_held", 32'(bus.dec_start), 0);
      step();
    end
    bus.dec_ready = 1'b1;
    #1;
    chk("dec_start", 32'(bus.dec_start), 1);
    chk("dec_data_in", 32'(bus.dec_data_in), 32'(word[idx]));
    chk("ready_issue", 32'(bus.req_ready), 0);
    step();
    #1;
    chk("start_once", 32'(bus.dec_start), 0);
    chk("busy_wait", 32'(busy), 1);
    for (int i = 1; i < int'(lat); i++) step();
    bus.dec_done     = 1'b1;
    bus.dec_data_out = dout;
    bus.dec_nerr     = nerr;
    bus.dec_fail     = fail;
    #1;
    chk("no_early_resp", 32'(bus.resp_valid), 0);
    step();
    bus.dec_done = 1'b0;
    bus.dec_fail = 1'b0;
    bus.dec_data_out = 5'h1F;
    bus.dec_nerr = 3'd7;
    #1;
    chk("resp_valid", 32'(bus.resp_valid), 32'(oh));
    chk("resp_data", 32'(bus.resp_data), 32'(dout));
    chk("resp_nerr", 32'(bus.resp_nerr), 32'(nerr));
    chk("resp_status", 32'(bus.resp_status), fail ? 1 : 0);
    step();
    #1;
    chk("resp_pulse", 32'(bus.resp_valid), 0);
    chk("resp_hold", 32'(bus.resp_data), 32'(dout));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    word[0] = 15'h1234 ^ 15'h0011;
    word[1] = 15'h0A5F;
    word[2] = 15'h7001;
    word[3] = 15'h3C3C;
    reset_n = 1'b0;
    bus.req_valid    = 4'b1111;
    bus.req_data     = {word[3], word[2], word[1], word[0]};
    bus.dec_ready    = 1'b1;
    bus.dec_done     = 1'b0;
    bus.dec_data_out = '0;
    bus.dec_nerr     = '0;
    bus.dec_fail     = 1'b0;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_dec_start", 32'(bus.dec_start), 0);
    chk("rst_dec_data_in", 32'(bus.dec_data_in), 0);
    chk("rst_resp_data", 32'(bus.resp_data), 0);
    chk("rst_resp_nerr", 32'(bus.resp_nerr), 0);
    chk("rst_resp_status", 32'(bus.resp_status), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    step();
    reset_n = 1'b1;

    // All four requesting continuously: order 0,1,2,3,0
    serve(0, 0, 1, 5'h03, 3'd0, 1'b0);
    serve(1, 0, 1, 5'h04, 3'd1, 1'b0);
    serve(2, 0, 1, 5'h05, 3'd2, 1'b0);
    serve(3, 0, 1, 5'h06, 3'd3, 1'b0);
    serve(0, 0, 1, 5'h07, 3'd1, 1'b0);

    // Single request, decoder done 6 cycles after start (resp on cycle 8)
    bus.req_valid = 4'b0001;
    serve(0, 0, 6, 5'h09, 3'd2, 1'b0);

    // Stray done in IDLE is ignored
    bus.req_valid = 4'b0000;
    bus.dec_done  = 1'b1;
    step();
    bus.dec_done = 1'b0;
    #1;
    chk("stray_done_busy", 32'(busy), 0);
    chk("stray_done_resp", 32'(bus.resp_valid), 0);

    // Decoder not ready for 5 cycles in ISSUE
    bus.req_valid = 4'b0100;
    serve(2, 5, 1, 5'h11, 3'd1, 1'b0);

    // Failure to owner 3, next grant wraps to 0
    bus.req_valid = 4'b1111;
    serve(3, 0, 2, 5'h15, 3'd3, 1'b1);
    serve(0, 0, 1, 5'h0A, 3'd2, 1'b0);

    // Decoder never completes
    bus.req_valid = 4'b0010;
    #1;
    chk("tmo_req_ready", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = 4'b0000;
    step();
`ifdef BCH_SCHED_TIMEOUT_EN
    for (int j = 0; j < 20; j++) begin
      #1;
      chk("tmo_wait", 32'(bus.resp_valid), 0);
      step();
    end
    #1;
    chk("tmo_resp_valid", 32'(bus.resp_valid), 32'h2);
    chk("tmo_status", 32'(bus.resp_status), 2);
    chk("tmo_data", 32'(bus.resp_data), 0);
    chk("tmo_nerr", 32'(bus.resp_nerr), 0);
    step();
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = 4'b0000;
    step();
    step();
`else
    for (int j = 0; j < 40; j++) begin
      #1;
      chk("hang_busy", 32'(busy), 1);
      chk("hang_resp", 32'(bus.resp_valid), 0);
      step();
    end
`endif

    // Reset mid-WAIT
    bus.req_valid = 4'b0100;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_dec_data_in", 32'(bus.dec_data_in), 0);
    chk("arst_resp_data", 32'(bus.resp_data), 0);
    chk("arst_resp_nerr", 32'(bus.resp_nerr), 0);
    chk("arst_resp_status", 32'(bus.resp_status), 0);
    chk("arst_req_ready", 32'(bus.req_ready), 0);
    bus.dec_done = 1'b1;
    step();
    bus.dec_done = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(bus.resp_valid), 0);
    chk("arst_dec_start", 32'(bus.dec_start), 0);
    step();
    reset_n = 1'b1;
    serve(2, 0, 1, 5'h1C, 3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
